decode_stage: RTL and testbench
===============================

# decode_stage

Buffered, pipelined MIPS instruction decode stage sitting between fetch and the register-read/execute path. Accepts `{pc, instr}` pairs over a valid/ready handshake into a DEPTH-entry queue, decodes the head entry into a registered output slot, and presents it downstream with its own valid/ready handshake. Unlike the combinational decoder, it derives immediate extension from the opcode, classifies branch/load/store, computes the destination register, supports flush, and counts back-pressure cycles.

## Interface
- `DEPTH`, 4: input queue entries; power of two, ≥2.
- `CNT_W`, 16: width of stall counter.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush_i` in 1: synchronous flush of queue and output slot.
- `instr_valid_i` in 1: upstream pair valid.
- `instr_ready_o` out 1: queue can accept.
- `instr_i` in 32: instruction word.
- `pc_i` in 32: instruction address.
- `valid_o` out 1: output slot holds a decoded instruction.
- `ready_i` in 1: downstream accepts output slot.
- `pc_o` out 32; `op_o` out 6; `rs_o`, `rt_o`, `rd_o`, `shamt_o` out 5 each; `funct_o` out 6; `target_o` out 26; `imm_o` out 32.
- `dest_o` out 5: architectural destination register (0 = none).
- `is_r_type_o`, `is_i_type_o`, `is_j_type_o`, `is_branch_o`, `is_load_o`, `is_store_o`, `use_link_reg_o` out 1 each.
- `count_o` out $clog2(DEPTH)+1: queue occupancy.
- `stall_cnt_o` out CNT_W: back-pressure cycle count.

## Operation
- Push: `instr_valid_i && instr_ready_o`; `instr_ready_o = !reset && count < DEPTH`.
- Output slot load: when slot empty or `valid_o && ready_i`, and queue non-empty, head is decoded and registered; head popped same edge. Push and pop in the same edge are legal at any occupancy below DEPTH; count unchanged.
- Flush (priority over push/pop): next edge count=0, pointers reset, `valid_o`=0; the input beat in the flush cycle is dropped. `stall_cnt_o` unaffected.
- Field extraction: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], target[25:0].
- Immediate: zero-extend instr[15:0] for op 0x0C/0x0D/0x0E (andi/ori/xori); sign-extend otherwise.
- Types: R = op 0x00; I = op≠0x00 and not J; J = op 0x02/0x03.
- is_branch: op 0x01, 0x04–0x07. is_load: op 0x20,0x21,0x23,0x24,0x25. is_store: op 0x28,0x29,0x2B.
- use_link_reg: (op 0x01 and rt 0x10/0x11) or (R-type and funct 0x09) or op 0x03.
- dest: 31 for op 0x03 and op 0x01 link forms; rd for R-type; 0 for stores, non-link branches, op 0x02; rt for all other I-type.
- stall_cnt_o: +1 each cycle `valid_o && !ready_i`, saturates at all-ones.
- Unlisted opcodes decode by the same rules; no illegal-instruction trap.

## Timing
- Reset (async assert): count=0, `valid_o`=0, all decoded outputs 0, `stall_cnt_o`=0, `instr_ready_o`=0 while reset high, 1 the cycle after deassert.
- Latency: pair pushed at edge k with empty queue and slot → `valid_o`=1 after edge k+1.
- Throughput: one instruction/cycle when `ready_i` held high.
- Output fields stable while `valid_o && !ready_i`.
- Full: count=DEPTH → `instr_ready_o`=0 same cycle; reasserts the cycle after a pop.
- Capacity: DEPTH in queue + 1 in slot.
- Reset mid-operation discards all queued entries immediately.

## Structure
- Package `mips_decode_pkg`: opcode/funct constants (OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI, load/store/branch opcodes, FUNCT_JALR, RT_BLTZAL, RT_BGEZAL), REG_RA=31, decoded-instruction struct.
- Sub-module `decode_fifo`: parametrised synchronous FIFO (DEPTH, WIDTH=64) with push/pop/flush/count; decode logic and output slot stay in `decode_stage`.

## Test plan
- Reset then push `0x0C100004` (jal) at pc 0x400000, ready_i=1 → valid_o after 2 edges, is_j=1, use_link=1, dest=31, target=0x0100004.
- Push `0x3421FFFF` (ori) then `0x2021FFFF` (addi) → imm_o 0x0000FFFF then 0xFFFFFFFF; dest=1 both.
- ready_i=0, push 6 instrs with DEPTH=4 → accepts 5, instr_ready_o=0, count_o=4, stall_cnt_o increments each cycle; release → all 5 emerge in order.
- Push `0x04110003` (bgezal), `0xAC220000` (sw), `0x00201009` (jalr) → is_branch/dest=31, is_store/dest=0, use_link/dest=2.
- Flush with 3 queued and slot valid, instr_valid_i=1 same cycle → next cycle count_o=0, valid_o=0, input beat dropped.
- Assert reset mid-stream with 2 queued → outputs zero immediately; post-release first pushed instr emerges with no stale entries.

Source files
------------

// File: rtl/mips_decode_pkg.sv
// mips_decode_pkg: MIPS opcode constants, decoded-instruction record and decode function
package mips_decode_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [25:0] target;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        is_r;
    logic        is_i;
    logic        is_j;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        use_link;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] pc, input logic [31:0] instr);
    dec_t d;
    logic link_b;
    d.pc        = pc;
    d.op        = instr[31:26];
    d.rs        = instr[25:21];
    d.rt        = instr[20:16];
    d.rd        = instr[15:11];
    d.shamt     = instr[10:6];
    d.funct     = instr[5:0];
    d.target    = instr[25:0];
    d.imm       = (d.op == OP_ANDI || d.op == OP_ORI || d.op == OP_XORI) ?
                  {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    d.is_r      = d.op == OP_SPECIAL;
    d.is_j      = d.op == OP_J || d.op == OP_JAL;
    d.is_i      = !d.is_r && !d.is_j;
    d.is_branch = d.op == OP_REGIMM || d.op == OP_BEQ || d.op == OP_BNE ||
                  d.op == OP_BLEZ || d.op == OP_BGTZ;
    d.is_load   = d.op == OP_LB || d.op == OP_LH || d.op == OP_LW ||
                  d.op == OP_LBU || d.op == OP_LHU;
    d.is_store  = d.op == OP_SB || d.op == OP_SH || d.op == OP_SW;
    link_b      = d.op == OP_REGIMM && (d.rt == RT_BLTZAL || d.rt == RT_BGEZAL);
    d.use_link  = link_b || (d.is_r && d.funct == FUNCT_JALR) || d.op == OP_JAL;
    d.dest      = (d.op == OP_JAL || link_b) ? REG_RA :
                  d.is_r ? d.rd :
                  (d.is_store || d.is_branch || d.op == OP_J) ? 5'd0 : d.rt;
    return d;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshakes of the decode stage
interface decode_stage_if #(parameter int DEPTH = 4, parameter int CNT_W = 16);
  logic                       flush_i;
  logic                       instr_valid_i;
  logic                       instr_ready_o;
  logic [31:0]                instr_i;
  logic [31:0]                pc_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [31:0]                pc_o;
  logic [5:0]                 op_o;
  logic [4:0]                 rs_o;
  logic [4:0]                 rt_o;
  logic [4:0]                 rd_o;
  logic [4:0]                 shamt_o;
  logic [5:0]                 funct_o;
  logic [25:0]                target_o;
  logic [31:0]                imm_o;
  logic [4:0]                 dest_o;
  logic                       is_r_type_o;
  logic                       is_i_type_o;
  logic                       is_j_type_o;
  logic                       is_branch_o;
  logic                       is_load_o;
  logic                       is_store_o;
  logic                       use_link_reg_o;
  logic [$clog2(DEPTH):0]     count_o;
  logic [CNT_W-1:0]           stall_cnt_o;

  modport slave (
    input  flush_i, instr_valid_i, instr_i, pc_i, ready_i,
    output instr_ready_o, valid_o, pc_o, op_o, rs_o, rt_o, rd_o, shamt_o, funct_o,
           target_o, imm_o, dest_o, is_r_type_o, is_i_type_o, is_j_type_o,
           is_branch_o, is_load_o, is_store_o, use_link_reg_o, count_o, stall_cnt_o
  );

  modport master (
    output flush_i, instr_valid_i, instr_i, pc_i, ready_i,
    input  instr_ready_o, valid_o, pc_o, op_o, rs_o, rt_o, rd_o, shamt_o, funct_o,
           target_o, imm_o, dest_o, is_r_type_o, is_i_type_o, is_j_type_o,
           is_branch_o, is_load_o, is_store_o, use_link_reg_o, count_o, stall_cnt_o
  );
endinterface

// File: rtl/decode_fifo.sv
// decode_fifo: synchronous FIFO with flush and occupancy count
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset; only entries below count are ever observed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: queued MIPS decoder with registered output slot, flush and stall counter
module decode_stage
  import mips_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);
  logic [63:0]      head;
  logic             empty, full, load;
  dec_t             slot_q, slot_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  assign bus.instr_ready_o = !reset && !full;
  assign load = (!valid_q || bus.ready_i) && !empty;

  decode_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.flush_i),
    .push_i  (bus.instr_valid_i && bus.instr_ready_o),
    .pop_i   (load),
    .data_i  ({bus.pc_i, bus.instr_i}),
    .data_o  (head),
    .count_o (bus.count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // slot refills from the queue head whenever it is empty or being consumed
  always_comb begin
    slot_d  = (load && !bus.flush_i) ? decode(head[63:32], head[31:0]) : slot_q;
    valid_d = bus.flush_i ? 1'b0 : load ? 1'b1 : (valid_q && bus.ready_i) ? 1'b0 : valid_q;
    stall_d = (valid_q && !bus.ready_i && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
  end

  // slot and counter registers; reset clears every visible decoded field
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign bus.valid_o        = valid_q;
  assign bus.pc_o           = slot_q.pc;
  assign bus.op_o           = slot_q.op;
  assign bus.rs_o           = slot_q.rs;
  assign bus.rt_o           = slot_q.rt;
  assign bus.rd_o           = slot_q.rd;
  assign bus.shamt_o        = slot_q.shamt;
  assign bus.funct_o        = slot_q.funct;
  assign bus.target_o       = slot_q.target;
  assign bus.imm_o          = slot_q.imm;
  assign bus.dest_o         = slot_q.dest;
  assign bus.is_r_type_o    = slot_q.is_r;
  assign bus.is_i_type_o    = slot_q.is_i;
  assign bus.is_j_type_o    = slot_q.is_j;
  assign bus.is_branch_o    = slot_q.is_branch;
  assign bus.is_load_o      = slot_q.is_load;
  assign bus.is_store_o     = slot_q.is_store;
  assign bus.use_link_reg_o = slot_q.use_link;
  assign bus.stall_cnt_o    = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, corner sequences and random traffic against a queue model
module tb_decode_stage;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();
  decode_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mq[$];
  bit          m_valid = 0;
  logic [63:0] m_slot = '0;
  int          m_stall = 0;

  typedef struct { logic [31:0] imm; logic [4:0] dest; logic [6:0] flags; } ref_t;
  typedef struct { logic [31:0] instr; logic [31:0] imm; logic [4:0] dest; logic [6:0] flags; } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // flags are {r, i, j, branch, load, store, link}
  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t e;
    int op = int'(w[31:26]);
    int rt = int'(w[20:16]);
    int rd = int'(w[15:11]);
    int fn = int'(w[5:0]);
    int s  = int'(w[15:0]);
    bit r  = op == 0;
    bit j  = op == 2 || op == 3;
    bit br = op == 1 || (op >= 4 && op <= 7);
    bit ld = op inside {32, 33, 35, 36, 37};
    bit st = op inside {40, 41, 43};
    bit lb = op == 1 && (rt == 16 || rt == 17);
    if (!(op inside {12, 13, 14}) && s >= 32768) s -= 65536;
    e.imm   = 32'(s);
    e.flags = {r, !r && !j, j, br, ld, st, lb || (r && fn == 9) || op == 3};
    if (op == 3 || lb) e.dest = 5'd31;
    else if (r) e.dest = 5'(rd);
    else if (st || br || op == 2) e.dest = 5'd0;
    else e.dest = 5'(rt);
    return e;
  endfunction

  function automatic logic [6:0] act_flags();
    return {bus.is_r_type_o, bus.is_i_type_o, bus.is_j_type_o, bus.is_branch_o,
            bus.is_load_o, bus.is_store_o, bus.use_link_reg_o};
  endfunction

  task automatic compare_all();
    ref_t e;
    check("valid", 64'(bus.valid_o), 64'(m_valid));
    check("count", 64'(bus.count_o), 64'(mq.size()));
    check("in_ready", 64'(bus.instr_ready_o), 64'(!reset && mq.size() < DEPTH));
    check("stall", 64'(bus.stall_cnt_o), 64'(m_stall));
    if (m_valid) begin
      e = ref_decode(m_slot[31:0]);
      check("pc", 64'(bus.pc_o), 64'(m_slot[63:32]));
      check("fields", 64'({bus.op_o, bus.rs_o, bus.rt_o, bus.rd_o, bus.shamt_o, bus.funct_o}), 64'(m_slot[31:0]));
      check("target", 64'(bus.target_o), 64'(m_slot[25:0]));
      check("imm", 64'(bus.imm_o), 64'(e.imm));
      check("dest", 64'(bus.dest_o), 64'(e.dest));
      check("flags", 64'(act_flags()), 64'(e.flags));
    end
  endtask

  task automatic cyc();
    bit vin = bus.instr_valid_i;
    bit rdy = bus.ready_i;
    bit fl  = bus.flush_i;
    bit ld;
    bit can_push;
    logic [63:0] w = {bus.pc_i, bus.instr_i};
    @(posedge clk);
    if (m_valid && !rdy && m_stall < STALL_MAX) m_stall++;
    if (fl) begin
      mq.delete();
      m_valid = 0;
    end else begin
      can_push = mq.size() < DEPTH;
      ld = (!m_valid || rdy) && mq.size() > 0;
      if (ld) begin
        m_slot = mq.pop_front();
        m_valid = 1;
      end else if (rdy) m_valid = 0;
      if (vin && can_push) mq.push_back(w);
    end
    #1;
    compare_all();
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    bus.instr_valid_i = 1'b1;
    bus.pc_i = pc;
    bus.instr_i = instr;
    cyc();
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(bus.valid_o), 64'(0));
    check({tag, "_count"}, 64'(bus.count_o), 64'(0));
    check({tag, "_ready"}, 64'(bus.instr_ready_o), 64'(0));
    check({tag, "_stall"}, 64'(bus.stall_cnt_o), 64'(0));
    check({tag, "_dest"}, 64'(bus.dest_o), 64'(0));
    check({tag, "_imm"}, 64'(bus.imm_o), 64'(0));
    check({tag, "_pc"}, 64'(bus.pc_o), 64'(0));
    check({tag, "_flags"}, 64'(act_flags()), 64'(0));
  endtask

  initial begin
    int acc;
    int n;
    logic [31:0] seen[$];
    tbl[0]  = '{32'h0C100004, 32'h00000004, 5'd31, 7'b0010001};
    tbl[1]  = '{32'h3421FFFF, 32'h0000FFFF, 5'd1,  7'b0100000};
    tbl[2]  = '{32'h2021FFFF, 32'hFFFFFFFF, 5'd1,  7'b0100000};
    tbl[3]  = '{32'h04110003, 32'h00000003, 5'd31, 7'b0101001};
    tbl[4]  = '{32'hAC220000, 32'h00000000, 5'd0,  7'b0100010};
    tbl[5]  = '{32'h00201009, 32'h00001009, 5'd2,  7'b1000001};
    tbl[6]  = '{32'h8C430008, 32'h00000008, 5'd3,  7'b0100100};
    tbl[7]  = '{32'h1000FFFE, 32'hFFFFFFFE, 5'd0,  7'b0101000};
    tbl[8]  = '{32'h08000010, 32'h00000010, 5'd0,  7'b0010000};
    tbl[9]  = '{32'h3042800F, 32'h0000800F, 5'd2,  7'b0100000};
    tbl[10] = '{32'h04100000, 32'h00000000, 5'd31, 7'b0101001};
    tbl[11] = '{32'h04010005, 32'h00000005, 5'd0,  7'b0101000};
    tbl[12] = '{32'h00851020, 32'h00001020, 5'd2,  7'b1000000};
    bus.flush_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.instr_i = '0;
    bus.pc_i = '0;
    bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(bus.instr_ready_o), 64'(1));
    bus.ready_i = 1'b1;

    foreach (tbl[i]) begin
      push_one(32'h00400000 + 32'(4 * i), tbl[i].instr);
      check("latency_not_yet", 64'(bus.valid_o), 64'(0));
      cyc();
      check("tbl_valid", 64'(bus.valid_o), 64'(1));
      check("tbl_imm", 64'(bus.imm_o), 64'(tbl[i].imm));
      check("tbl_dest", 64'(bus.dest_o), 64'(tbl[i].dest));
      check("tbl_flags", 64'(act_flags()), 64'(tbl[i].flags));
      if (i == 0) check("jal_target", 64'(bus.target_o), 64'(26'h0100004));
    end
    cyc();

    // capacity: slot plus DEPTH queue entries accepted under back-pressure
    bus.ready_i = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.instr_ready_o) acc++;
      push_one(32'h1000 + 32'(4 * k), 32'h20000000 + 32'(k));
    end
    check("accepted", 64'(acc), 64'(5));
    check("full_count", 64'(bus.count_o), 64'(DEPTH));
    check("full_ready", 64'(bus.instr_ready_o), 64'(0));
    bus.ready_i = 1'b1;
    n = 0;
    while (n < 20 && (bus.valid_o || bus.count_o != 0)) begin
      if (bus.valid_o) seen.push_back(bus.pc_o);
      cyc();
      n++;
    end
    check("drain_bound", 64'(n < 20), 64'(1));
    check("drained", 64'(seen.size()), 64'(5));
    foreach (seen[k]) check("order", 64'(seen[k]), 64'(32'h1000 + 32'(4 * k)));

    // stall counter saturation
    push_one(32'h2000, 32'h00000000);
    bus.ready_i = 1'b0;
    repeat (40) cyc();
    check("stall_sat", 64'(bus.stall_cnt_o), 64'(STALL_MAX));
    bus.ready_i = 1'b1;
    cyc();

    // flush with slot valid and three queued, live input beat dropped
    bus.ready_i = 1'b0;
    for (int k = 0; k < 4; k++) push_one(32'h3000 + 32'(4 * k), 32'h8C000000 + 32'(k));
    check("pre_flush_count", 64'(bus.count_o), 64'(3));
    check("pre_flush_valid", 64'(bus.valid_o), 64'(1));
    bus.flush_i = 1'b1;
    push_one(32'h3FFC, 32'hAC000000);
    bus.flush_i = 1'b0;
    check("flush_count", 64'(bus.count_o), 64'(0));
    check("flush_valid", 64'(bus.valid_o), 64'(0));
    bus.ready_i = 1'b1;
    cyc();
    check("flush_dropped", 64'(bus.count_o), 64'(0));
    cyc();

    // async reset mid-stream with two queued
    bus.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) push_one(32'h5000 + 32'(4 * k), 32'h3C000000 + 32'(k));
    check("pre_reset_count", 64'(bus.count_o), 64'(2));
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    mq.delete();
    m_valid = 0;
    m_stall = 0;
    @(negedge clk);
    reset = 1'b0;
    bus.ready_i = 1'b1;
    push_one(32'h6000, 32'h00851020);
    cyc();
    check("post_reset_pc", 64'(bus.pc_o), 64'(32'h6000));
    cyc();
    check("no_stale", 64'(bus.valid_o), 64'(0));

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      bus.instr_valid_i = 1'($urandom_range(0, 1));
      bus.instr_i = $urandom;
      bus.pc_i = $urandom;
      bus.ready_i = $urandom_range(0, 3) != 0;
      bus.flush_i = $urandom_range(0, 24) == 0;
      cyc();
    end
    bus.flush_i = 1'b0;
    bus.instr_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
